// File: rtl/shiftreg_arbiter.sv
// rtl/shiftreg_arbiter.sv - round-robin burst arbiter sharing one shift register, with return-path tag routing
module shiftreg_arbiter #(
   parameter int NumReq    = 4,
   parameter int DataWidth = 32,
   parameter int Depth     = 4,
   parameter int MaxBurst  = 2
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic [NumReq-1:0]             req_valid_i,
   input  logic [NumReq*DataWidth-1:0]   req_data_i,
   output logic [NumReq-1:0]             req_ready_o,
   output logic                          sr_valid_o,
   output logic [DataWidth-1:0]          sr_data_o,
   input  logic                          sr_valid_i,
   input  logic [DataWidth-1:0]          sr_data_i,
   output logic [NumReq-1:0]             rsp_valid_o,
   output logic [DataWidth-1:0]          rsp_data_o,
   output logic                          busy_o,
   output logic                          error_o
);

   localparam int IdW  = $clog2(NumReq);
   localparam int CntW = $clog2(MaxBurst + 1);
   localparam logic [IdW-1:0]  LastId  = IdW'(NumReq - 1);
   localparam logic [CntW-1:0] BurstLen = CntW'(MaxBurst);

   typedef enum logic {IDLE, BURST} state_t;

   state_t          state_q, state_d;
   logic [IdW-1:0]  ptr_q, ptr_d;
   logic [IdW-1:0]  owner_q, owner_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [IdW-1:0]  win_id;
   logic            found;
   logic            transfer;
   logic [Depth-1:0] tag_v_q;
   logic [IdW-1:0]  tag_id_q [Depth];
   logic            error_q;

   // Requester index after id, wrapping at the last requester.
   function automatic logic [IdW-1:0] next_id(input logic [IdW-1:0] id);
      return (id == LastId) ? '0 : id + 1'b1;
   endfunction

   // Requester index base+off taken modulo NumReq.
   function automatic logic [IdW-1:0] rr_idx(input logic [IdW-1:0] base, input int off);
      int s;
      s = int'(base) + off;
      if (s >= NumReq) s = s - NumReq;
      return IdW'(s);
   endfunction

   // Arbitration FSM state, round-robin pointer, burst owner and beat counter.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         owner_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         owner_q <= owner_d;
         cnt_q   <= cnt_d;
      end
   end

   // Winner selection and next-state: round-robin scan when idle, owner-only while locked.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      owner_d = owner_q;
      cnt_d   = cnt_q;
      win_id  = '0;
      found   = 1'b0;
      unique case (state_q)
         IDLE: begin
            for (int i = 0; i < NumReq; i++) begin
               if (!found && req_valid_i[rr_idx(ptr_q, i)]) begin
                  found  = 1'b1;
                  win_id = rr_idx(ptr_q, i);
               end
            end
            if (found) begin
               if (MaxBurst == 1) begin
                  ptr_d = next_id(win_id);
               end else begin
                  state_d = BURST;
                  owner_d = win_id;
                  cnt_d   = CntW'(1);
               end
            end
         end
         BURST: begin
            win_id = owner_q;
            found  = req_valid_i[owner_q];
            if (found) begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q + 1'b1 == BurstLen) begin
                  state_d = IDLE;
                  ptr_d   = next_id(owner_q);
                  cnt_d   = '0;
               end
            end else begin
               // Owner dropped its request: release the lock, costing one idle cycle.
               state_d = IDLE;
               ptr_d   = next_id(owner_q);
               cnt_d   = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Grant is suppressed while reset is asserted so nothing enters the register.
   assign req_ready_o = (found && rst_ni) ? (NumReq'(1) << win_id) : '0;
   assign transfer    = |(req_valid_i & req_ready_o);
   assign sr_valid_o  = transfer;
   assign sr_data_o   = transfer ? req_data_i[win_id*DataWidth +: DataWidth] : '0;

   // Tag pipe mirroring the shift register: carries the issuing requester id.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         tag_v_q <= '0;
         for (int i = 0; i < Depth; i++) tag_id_q[i] <= '0;
      end else begin
         tag_v_q[0]  <= transfer;
         tag_id_q[0] <= win_id;
         for (int i = 1; i < Depth; i++) begin
            tag_v_q[i]  <= tag_v_q[i-1];
            tag_id_q[i] <= tag_id_q[i-1];
         end
      end
   end

   // Sticky flag raised whenever the register output disagrees with the head tag.
   always_ff @(posedge clk_i) begin
      if (!rst_ni)                               error_q <= 1'b0;
      else if (sr_valid_i != tag_v_q[Depth-1])   error_q <= 1'b1;
   end

   assign rsp_valid_o = sr_valid_i ? (NumReq'(1) << tag_id_q[Depth-1]) : '0;
   assign rsp_data_o  = sr_valid_i ? sr_data_i : '0;
   assign busy_o      = |tag_v_q;
   assign error_o     = error_q;

endmodule

// File: tb/tb_shiftreg_arbiter.sv
// tb/tb_shiftreg_arbiter.sv - scoreboard bench for shiftreg_arbiter at MaxBurst 1, 2 and 4
module tb_shiftreg_arbiter;

   localparam int NR = 4;
   localparam int DW = 32;
   localparam int DP = 4;

   typedef struct {
      int             cyc;
      int             id;
      logic [DW-1:0]  data;
   } exp_t;

   logic                    clk = 1'b0;
   logic                    rst_n;
   logic [NR-1:0]           req_valid;
   logic [NR*DW-1:0]        req_data;
   logic                    inject;
   logic                    mon_en;
   logic [1:0]              sel;

   logic [2:0][NR-1:0]      ready;
   logic [2:0][NR-1:0]      rsp_valid;
   logic [2:0][DW-1:0]      sr_d_o, sr_d_i, rsp_data;
   logic [2:0]              sr_v_o, sr_v_i, busy, err;
   logic [2:0][DP-1:0]      model_v;
   logic [2:0][DP-1:0][DW-1:0] model_d;

   int   cyc = 0;
   int   n_checks = 0;
   int   n_pass = 0;
   exp_t exp_q[$];
   int   grant_log[$];
   exp_t mon_e;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Three instances differing only in MaxBurst, each with its own shift register model.
   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int MB = (g == 0) ? 1 : ((g == 1) ? 2 : 4);

      shiftreg_arbiter #(
         .NumReq(NR), .DataWidth(DW), .Depth(DP), .MaxBurst(MB)
      ) u_dut (
         .clk_i       (clk),
         .rst_ni      (rst_n),
         .req_valid_i (req_valid),
         .req_data_i  (req_data),
         .req_ready_o (ready[g]),
         .sr_valid_o  (sr_v_o[g]),
         .sr_data_o   (sr_d_o[g]),
         .sr_valid_i  (sr_v_i[g]),
         .sr_data_i   (sr_d_i[g]),
         .rsp_valid_o (rsp_valid[g]),
         .rsp_data_o  (rsp_data[g]),
         .busy_o      (busy[g]),
         .error_o     (err[g])
      );

      always @(posedge clk) begin
         if (!rst_n) model_v[g] <= '0;
         else        model_v[g] <= {model_v[g][DP-2:0], sr_v_o[g]};
         model_d[g] <= {model_d[g][DP-2:0], sr_d_o[g]};
      end

      assign sr_v_i[g] = model_v[g][DP-1] | (inject && (sel == 2'(g)));
      assign sr_d_i[g] = model_d[g][DP-1];
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_checks++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, want);
   endtask

   function automatic int oh2idx(input logic [NR-1:0] v);
      int r = 0;
      for (int i = 0; i < NR; i++) if (v[i]) r = i;
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic new_data();
      for (int k = 0; k < NR; k++) req_data[k*DW +: DW] = $urandom();
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      exp_q.delete();
      grant_log.delete();
   endtask

   // Scoreboard: push each accepted beat, pop and compare when a response appears.
   always @(negedge clk) begin
      if (mon_en && rst_n) begin
         if (ready[sel] != '0)
            check_eq("ready_only_valid", 64'(ready[sel] & ~req_valid), 64'(0));
         if (rsp_valid[sel] != '0) begin
            if (exp_q.size() == 0) begin
               check_eq("rsp_unexpected", 64'(rsp_valid[sel]), 64'(0));
            end else begin
               mon_e = exp_q.pop_front();
               check_eq("rsp_port", 64'(rsp_valid[sel]), 64'(1) << mon_e.id);
               check_eq("rsp_data", 64'(rsp_data[sel]), 64'(mon_e.data));
               check_eq("rsp_latency", 64'(cyc - mon_e.cyc), 64'(DP));
            end
         end else if (exp_q.size() > 0 && (cyc - exp_q[0].cyc) >= DP) begin
            mon_e = exp_q.pop_front();
            check_eq("rsp_missing", 64'(rsp_valid[sel]), 64'(1) << mon_e.id);
         end
         if (sr_v_o[sel]) begin
            mon_e.cyc  = cyc;
            mon_e.id   = oh2idx(ready[sel]);
            mon_e.data = req_data[mon_e.id*DW +: DW];
            check_eq("sr_data", 64'(sr_d_o[sel]), 64'(mon_e.data));
            exp_q.push_back(mon_e);
            grant_log.push_back(mon_e.id);
         end
      end
   end

   initial begin
      int exp_g2 [9];
      exp_g2 = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
      rst_n     = 1'b0;
      req_valid = '1;
      req_data  = '0;
      inject    = 1'b0;
      mon_en    = 1'b0;
      sel       = 2'd0;
      idle(2);

      // Reset state and outputs held quiet while reset is asserted.
      for (int g = 0; g < 3; g++) begin
         check_eq("rst_ready", 64'(ready[2'(g)]), 64'(0));
         check_eq("rst_sr_valid", 64'(sr_v_o[2'(g)]), 64'(0));
         check_eq("rst_busy", 64'(busy[2'(g)]), 64'(0));
         check_eq("rst_error", 64'(err[2'(g)]), 64'(0));
      end
      req_valid = '0;
      rst_n     = 1'b1;
      mon_en    = 1'b1;
      exp_q.delete();
      grant_log.delete();

      // Single requester streaming back-to-back, MaxBurst=1.
      sel = 2'd0;
      for (int i = 0; i < 4; i++) begin
         req_valid = 4'b0001;
         new_data();
         tick();
      end
      req_valid = '0;
      idle(DP + 2);
      check_eq("t1_grant_count", 64'(grant_log.size()), 64'(4));
      foreach (grant_log[i]) check_eq("t1_grant_id", 64'(grant_log[i]), 64'(0));
      check_eq("t1_drained", 64'(exp_q.size()), 64'(0));
      check_eq("t1_error", 64'(err[0]), 64'(0));

      // Full contention with MaxBurst=2.
      sel = 2'd1;
      pulse_reset();
      req_valid = 4'b1111;
      for (int i = 0; i < 9; i++) begin
         new_data();
         tick();
      end
      req_valid = '0;
      idle(DP + 2);
      check_eq("t2_grant_count", 64'(grant_log.size()), 64'(9));
      for (int i = 0; i < 9 && i < grant_log.size(); i++)
         check_eq("t2_grant_seq", 64'(grant_log[i]), 64'(exp_g2[i]));
      check_eq("t2_drained", 64'(exp_q.size()), 64'(0));
      check_eq("t2_error", 64'(err[1]), 64'(0));

      // Burst cut by owner dropping valid, MaxBurst=4.
      sel = 2'd2;
      pulse_reset();
      req_valid = 4'b0110;
      new_data();
      #1 check_eq("t3_grant_req1", 64'(ready[2]), 64'(4'b0010));
      tick();
      req_valid = 4'b0100;
      #1 check_eq("t3_bubble", 64'(ready[2]), 64'(0));
      tick();
      #1 check_eq("t3_grant_req2", 64'(ready[2]), 64'(4'b0100));
      tick();
      req_valid = '0;
      idle(DP + 2);
      check_eq("t3_grant_count", 64'(grant_log.size()), 64'(2));
      if (grant_log.size() == 2) begin
         check_eq("t3_first", 64'(grant_log[0]), 64'(1));
         check_eq("t3_second", 64'(grant_log[1]), 64'(2));
      end
      check_eq("t3_drained", 64'(exp_q.size()), 64'(0));

      // Reset while three beats are in flight.
      sel = 2'd0;
      pulse_reset();
      for (int i = 0; i < 3; i++) begin
         req_valid = 4'b0001;
         new_data();
         tick();
      end
      check_eq("t4_busy_before", 64'(busy[0]), 64'(1));
      req_valid = 4'b1111;
      rst_n = 1'b0;
      #1;
      check_eq("t4_ready_in_reset", 64'(ready[0]), 64'(0));
      check_eq("t4_srv_in_reset", 64'(sr_v_o[0]), 64'(0));
      tick();
      rst_n = 1'b1;
      req_valid = '0;
      exp_q.delete();
      grant_log.delete();
      check_eq("t4_busy_after", 64'(busy[0]), 64'(0));
      for (int i = 0; i < DP + 1; i++) begin
         tick();
         check_eq("t4_no_rsp", 64'(rsp_valid[0]), 64'(0));
      end
      req_valid = 4'b1111;
      new_data();
      #1 check_eq("t4_first_grant", 64'(ready[0]), 64'(4'b0001));
      tick();
      req_valid = '0;
      idle(DP + 2);
      check_eq("t4_drained", 64'(exp_q.size()), 64'(0));
      check_eq("t4_error", 64'(err[0]), 64'(0));

      // Response valid with an empty tag pipe must raise a sticky error.
      sel = 2'd0;
      pulse_reset();
      mon_en = 1'b0;
      inject = 1'b1;
      #1 check_eq("t5_pre_edge", 64'(err[0]), 64'(0));
      tick();
      inject = 1'b0;
      check_eq("t5_set", 64'(err[0]), 64'(1));
      for (int i = 0; i < 3; i++) begin
         tick();
         check_eq("t5_sticky", 64'(err[0]), 64'(1));
      end
      pulse_reset();
      check_eq("t5_cleared", 64'(err[0]), 64'(0));
      mon_en = 1'b1;

      // Fairness: req3 always valid, req0 toggling, MaxBurst=1 -> alternating grants.
      sel = 2'd0;
      pulse_reset();
      for (int i = 0; i < 20; i++) begin
         req_valid = {1'b1, 2'b00, (i % 2 == 0)};
         new_data();
         tick();
      end
      req_valid = '0;
      idle(DP + 2);
      check_eq("t6_grant_count", 64'(grant_log.size()), 64'(20));
      for (int i = 0; i < 20 && i < grant_log.size(); i++)
         check_eq("t6_grant_seq", 64'(grant_log[i]), 64'((i % 2 == 0) ? 0 : 3));
      check_eq("t6_drained", 64'(exp_q.size()), 64'(0));
      check_eq("t6_error", 64'(err[0]), 64'(0));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
